fc_tx_credit_gate_mc: RTL and testbench
=======================================

// Module: fc_tx_credit_gate_mc
// PURPOSE
//  Parametrised successor TX flow-control gate, NUM_TYPES credit types (default MWr/MRd/Cpl).
//  Owns the FC init state machine (FC_INIT1 -> FC_INIT2 -> READY) and per-type credit limits (CL).
//  Owns per-type consumed counters (CC), modulo-2^W gating and infinite-credit mode.
//  Sits between DLLP RX decode and the TLP TX buffer; grants TLPs through a valid/ready handshake.
// PARAMETERS
//  NUM_TYPES      3   credit types; type index 0..NUM_TYPES-1 (0 MWr, 1 MRd, 2 Cpl)
//  HDR_W          8   header credit field / counter width
//  DATA_W        12   data credit field / counter width
//  SIZE_W        10   TLP payload size width, DW units
//  DW_PER_CRED    4   DW per data credit, power of two
// PORTS
//  clk             in   1          clock
//  rst_n           in   1          async active-low reset
//  fc_reinit_i     in   1          sync restart of FC init (link down); 1-cycle pulse
//  dllp_valid_i    in   1          FC DLLP valid this cycle
//  dllp_kind_i     in   2          01 InitFC1, 11 InitFC2, 10 UpdateFC, 00 ignored
//  dllp_type_i     in   TYPE_W     credit type, TYPE_W=$clog2(NUM_TYPES)
//  dllp_hdr_fc_i   in   HDR_W      HdrFC field
//  dllp_data_fc_i  in   DATA_W     DataFC field
//  req_valid_i     in   1          TLP send request
//  req_type_i      in   TYPE_W     request credit type
//  req_size_i      in   SIZE_W     payload DW (0 = no data)
//  req_ready_o     out  1          grant; TLP consumed when req_valid_i && req_ready_o
//  fc_ready_o      out  1          1 while in READY
// BEHAVIOUR
//  Reset / fc_reinit_i: state=FC_INIT1; all CL, CC, infinite flags, init bitmap = 0.
//   Outputs 0. fc_reinit_i wins over every same-cycle event.
//  FC_INIT1: InitFC1 for type t with init bit t clear -> CL_hdr[t]/CL_data[t] = fields, set bit t.
//   hdr_inf[t]/data_inf[t] = (field==0). Repeat InitFC1 for a recorded type ignored.
//   InitFC2/UpdateFC ignored. All NUM_TYPES bits set -> FC_INIT2 next cycle.
//  FC_INIT2: first InitFC2 or UpdateFC (any type) -> READY; its field values are discarded.
//  READY: UpdateFC type t -> CL_hdr[t]/CL_data[t] = fields, except fields flagged infinite (held).
//   InitFC1/InitFC2 ignored. Stays READY until reset/fc_reinit_i.
//  Unknown type (>= NUM_TYPES) on DLLP ignored; on request -> req_ready_o=0.
//  Required credits: hdr=1; data=ceil(req_size_i/DW_PER_CRED) (size 0 -> 0), width DATA_W.
//  Field passes if infinite, or ((CL-(CC+req)) mod 2^W) <= 2^(W-1); hdr and data both must pass.
//  req_ready_o combinational: fc_ready_o && req_valid_i && type valid && both pass.
//   Computed from registered CL/CC only; same-cycle UpdateFC takes effect next cycle.
//  On handshake: CC_hdr[t] += 1, CC_data[t] += req data, mod 2^W, next edge, wraps freely.
//   Infinite fields are not counted.
//  UpdateFC and handshake on same type same cycle: both applied (CL load, CC increment).
//  req_ready_o may drop while req_valid_i held (no credits); request must stay stable until granted.
//  No latency beyond above: one grant per cycle, back-to-back grants allowed.
// TESTING
//  InitFC1 t0..2 (hdr 4, data 16), InitFC2 -> fc_ready_o=1 cycle after InitFC2; not before.
//  READY, MWr size 16DW x4 -> 4 grants, CC_data=16; 5th stalls; UpdateFC data=20 -> granted next cycle.
//  InitFC1 Cpl hdr=0 data=0 -> 1000 Cpl size 64 granted; ready never drops; CC_Cpl stays 0.
//  CL_hdr=0x02, CC_hdr=0xFF -> MRd granted 3x across wrap (CC 00,01,02); 4th stalls.
//  Exactly 2^(DATA_W-1) diff: CL-CC-req=2048 -> pass; 2049 -> stall.
//  Mid-traffic fc_reinit_i with req_valid_i=1 -> req_ready_o=0 same cycle; state FC_INIT1, CL/CC=0.
//  Mid-traffic rst_n low -> same as fc_reinit_i, asynchronously.

Source files
------------

// File: rtl/fc_tx_credit_gate_mc.sv
// Purpose: TX flow-control gate; runs FC init (INIT1->INIT2->READY), keeps per-type credit limits/consumed counters.
// Latency: req_ready_o is combinational from registered CL/CC; DLLP updates and consumption land on the next edge.
// Backpressure: req_ready_o low when credits are short or FC not ready; requester holds its request until granted.
module fc_tx_credit_gate_mc #(
  parameter int NUM_TYPES   = 3,
  parameter int HDR_W       = 8,
  parameter int DATA_W      = 12,
  parameter int SIZE_W      = 10,
  parameter int DW_PER_CRED = 4,
  localparam int TYPE_W     = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fc_reinit_i,
  input  logic              dllp_valid_i,
  input  logic [1:0]        dllp_kind_i,
  input  logic [TYPE_W-1:0] dllp_type_i,
  input  logic [HDR_W-1:0]  dllp_hdr_fc_i,
  input  logic [DATA_W-1:0] dllp_data_fc_i,
  input  logic              req_valid_i,
  input  logic [TYPE_W-1:0] req_type_i,
  input  logic [SIZE_W-1:0] req_size_i,
  output logic              req_ready_o,
  output logic              fc_ready_o
);

  localparam logic [1:0] KIND_INIT1 = 2'b01;
  localparam logic [1:0] KIND_INIT2 = 2'b11;
  localparam logic [1:0] KIND_UPD   = 2'b10;
  localparam int CRED_SHIFT = $clog2(DW_PER_CRED);
  // Largest modular headroom still treated as "enough credit" (half the counter range).
  localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [NUM_TYPES-1:0] ALL_TYPES = '1;

  typedef enum logic [1:0] {
    FC_INIT1 = 2'd0,
    FC_INIT2 = 2'd1,
    READY    = 2'd2
  } fc_state_e;

  fc_state_e r_state;
  fc_state_e w_state_nxt;

  logic [NUM_TYPES-1:0] r_init_bits;
  logic [NUM_TYPES-1:0] r_hdr_inf;
  logic [NUM_TYPES-1:0] r_data_inf;
  logic [HDR_W-1:0]     r_cl_hdr  [NUM_TYPES];
  logic [HDR_W-1:0]     r_cc_hdr  [NUM_TYPES];
  logic [DATA_W-1:0]    r_cl_data [NUM_TYPES];
  logic [DATA_W-1:0]    r_cc_data [NUM_TYPES];

  logic                 w_dllp_ok;
  logic                 w_req_type_ok;
  logic [TYPE_W-1:0]    w_req_idx;
  logic [SIZE_W:0]      w_size_rnd;
  logic [DATA_W-1:0]    w_req_data;
  logic [HDR_W-1:0]     w_hdr_diff;
  logic [DATA_W-1:0]    w_data_diff;
  logic                 w_hdr_pass;
  logic                 w_data_pass;
  logic [NUM_TYPES-1:0] w_init_load;
  logic [NUM_TYPES-1:0] w_upd_load;
  logic [NUM_TYPES-1:0] w_hs;
  logic [NUM_TYPES-1:0] w_init_bits_nxt;

  assign w_dllp_ok     = dllp_valid_i && (int'(dllp_type_i) < NUM_TYPES);
  assign w_req_type_ok = int'(req_type_i) < NUM_TYPES;
  // Out-of-range types are never granted; steer their lookup to entry 0 to stay in bounds.
  assign w_req_idx     = w_req_type_ok ? req_type_i : '0;

  // Data credits needed: payload DW rounded up to whole credits.
  assign w_size_rnd  = {1'b0, req_size_i} + (SIZE_W+1)'(DW_PER_CRED - 1);
  assign w_req_data  = DATA_W'(w_size_rnd >> CRED_SHIFT);

  // Modular headroom after this request; anything above half range means the limit is behind us.
  assign w_hdr_diff  = r_cl_hdr[w_req_idx] - r_cc_hdr[w_req_idx] - HDR_W'(1);
  assign w_data_diff = r_cl_data[w_req_idx] - r_cc_data[w_req_idx] - w_req_data;
  assign w_hdr_pass  = r_hdr_inf[w_req_idx] || (w_hdr_diff <= HDR_HALF);
  assign w_data_pass = r_data_inf[w_req_idx] || (w_data_diff <= DATA_HALF);

  // A pending reinit blanks both outputs in the same cycle it is raised.
  assign fc_ready_o  = (r_state == READY) && !fc_reinit_i;
  assign req_ready_o = fc_ready_o && req_valid_i && w_req_type_ok && w_hdr_pass && w_data_pass;

  // Per-type load/consume strobes decoded from the DLLP and request ports.
  always_comb begin
    w_init_load = '0;
    w_upd_load  = '0;
    w_hs        = '0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      w_init_load[t] = w_dllp_ok && (dllp_type_i == TYPE_W'(t)) && (dllp_kind_i == KIND_INIT1) &&
                       (r_state == FC_INIT1) && !r_init_bits[t];
      w_upd_load[t]  = w_dllp_ok && (dllp_type_i == TYPE_W'(t)) && (dllp_kind_i == KIND_UPD) &&
                       (r_state == READY);
      w_hs[t]        = req_ready_o && (w_req_idx == TYPE_W'(t));
    end
  end

  assign w_init_bits_nxt = r_init_bits | w_init_load;

  // FC init state register; reinit restarts the handshake from FC_INIT1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FC_INIT1;
    end else if (fc_reinit_i) begin
      r_state <= FC_INIT1;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FC init next-state: all types recorded -> INIT2; first InitFC2/UpdateFC there -> READY.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FC_INIT1: begin
        if (w_init_bits_nxt == ALL_TYPES) begin
          w_state_nxt = FC_INIT2;
        end
      end
      FC_INIT2: begin
        if (w_dllp_ok && ((dllp_kind_i == KIND_INIT2) || (dllp_kind_i == KIND_UPD))) begin
          w_state_nxt = READY;
        end
      end
      READY:   w_state_nxt = READY;
      default: w_state_nxt = FC_INIT1;
    endcase
  end

  // Credit limits, infinite flags and init bitmap; infinite fields ignore later updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_bits <= '0;
      r_hdr_inf   <= '0;
      r_data_inf  <= '0;
      for (int t = 0; t < NUM_TYPES; t++) begin
        r_cl_hdr[t]  <= '0;
        r_cl_data[t] <= '0;
      end
    end else if (fc_reinit_i) begin
      r_init_bits <= '0;
      r_hdr_inf   <= '0;
      r_data_inf  <= '0;
      for (int t = 0; t < NUM_TYPES; t++) begin
        r_cl_hdr[t]  <= '0;
        r_cl_data[t] <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        if (w_init_load[t]) begin
          r_init_bits[t] <= 1'b1;
          r_cl_hdr[t]    <= dllp_hdr_fc_i;
          r_cl_data[t]   <= dllp_data_fc_i;
          r_hdr_inf[t]   <= (dllp_hdr_fc_i == '0);
          r_data_inf[t]  <= (dllp_data_fc_i == '0);
        end else if (w_upd_load[t]) begin
          if (!r_hdr_inf[t]) begin
            r_cl_hdr[t] <= dllp_hdr_fc_i;
          end
          if (!r_data_inf[t]) begin
            r_cl_data[t] <= dllp_data_fc_i;
          end
        end
      end
    end
  end

  // Consumed counters advance on each grant and wrap freely; infinite fields stay at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        r_cc_hdr[t]  <= '0;
        r_cc_data[t] <= '0;
      end
    end else if (fc_reinit_i) begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        r_cc_hdr[t]  <= '0;
        r_cc_data[t] <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        if (w_hs[t]) begin
          if (!r_hdr_inf[t]) begin
            r_cc_hdr[t] <= r_cc_hdr[t] + HDR_W'(1);
          end
          if (!r_data_inf[t]) begin
            r_cc_data[t] <= r_cc_data[t] + w_req_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_tx_credit_gate_mc.sv
// Directed bench for fc_tx_credit_gate_mc: table of combinational grant checks plus multi-cycle sequences.
// Inputs change on the falling edge; outputs are sampled 1ns after it, away from the rising edge.
// Expected values are hand-computed from the credit arithmetic.
module tb_fc_tx_credit_gate_mc;

  localparam logic [1:0] K_INIT1 = 2'b01;
  localparam logic [1:0] K_INIT2 = 2'b11;
  localparam logic [1:0] K_UPD   = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fc_reinit_i;
  logic        dllp_valid_i;
  logic [1:0]  dllp_kind_i;
  logic [1:0]  dllp_type_i;
  logic [7:0]  dllp_hdr_fc_i;
  logic [11:0] dllp_data_fc_i;
  logic        req_valid_i;
  logic [1:0]  req_type_i;
  logic [9:0]  req_size_i;
  logic        req_ready_o;
  logic        fc_ready_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] typ;
    logic [9:0] size;
    logic       vld;
    logic       exp_rdy;
    string      name;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  fc_tx_credit_gate_mc dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fc_reinit_i    (fc_reinit_i),
    .dllp_valid_i   (dllp_valid_i),
    .dllp_kind_i    (dllp_kind_i),
    .dllp_type_i    (dllp_type_i),
    .dllp_hdr_fc_i  (dllp_hdr_fc_i),
    .dllp_data_fc_i (dllp_data_fc_i),
    .req_valid_i    (req_valid_i),
    .req_type_i     (req_type_i),
    .req_size_i     (req_size_i),
    .req_ready_o    (req_ready_o),
    .fc_ready_o     (fc_ready_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One-cycle DLLP, launched on a falling edge; returns on the falling edge after capture.
  task automatic dllp(input logic [1:0] kind, input logic [1:0] typ, input logic [7:0] hdr,
                      input logic [11:0] data);
    @(negedge clk);
    dllp_valid_i   = 1'b1;
    dllp_kind_i    = kind;
    dllp_type_i    = typ;
    dllp_hdr_fc_i  = hdr;
    dllp_data_fc_i = data;
    @(negedge clk);
    dllp_valid_i   = 1'b0;
    dllp_kind_i    = 2'b00;
  endtask

  task automatic reinit();
    @(negedge clk);
    fc_reinit_i = 1'b1;
    @(negedge clk);
    fc_reinit_i = 1'b0;
  endtask

  task automatic do_init(input logic [7:0] h0, input logic [11:0] d0, input logic [7:0] h1,
                         input logic [11:0] d1, input logic [7:0] h2, input logic [11:0] d2);
    dllp(K_INIT1, 2'd0, h0, d0);
    dllp(K_INIT1, 2'd1, h1, d1);
    dllp(K_INIT1, 2'd2, h2, d2);
    dllp(K_INIT2, 2'd0, 8'd0, 12'd0);
  endtask

  // Holds a request for n cycles starting at a falling edge; returns the number of grants seen.
  task automatic hold_req(input logic [1:0] typ, input logic [9:0] size, input int n, output int grants);
    grants = 0;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_type_i  = typ;
    req_size_i  = size;
    for (int i = 0; i < n; i++) begin
      #1;
      if (req_ready_o) grants++;
      @(negedge clk);
    end
    req_valid_i = 1'b0;
  endtask

  initial begin
    int g;
    rst_n          = 1'b0;
    fc_reinit_i    = 1'b0;
    dllp_valid_i   = 1'b0;
    dllp_kind_i    = 2'b00;
    dllp_type_i    = 2'd0;
    dllp_hdr_fc_i  = '0;
    dllp_data_fc_i = '0;
    req_valid_i    = 1'b1;
    req_type_i     = 2'd0;
    req_size_i     = '0;

    // Credit state for the table: MWr hdr 4 data 2049, MRd hdr 4 data 16, Cpl infinite.
    vecs[0]  = '{2'd0, 10'd0,    1'b1, 1'b0, "mwr_sz0_diff2049"};
    vecs[1]  = '{2'd0, 10'd1,    1'b1, 1'b1, "mwr_sz1_diff2048"};
    vecs[2]  = '{2'd0, 10'd4,    1'b1, 1'b1, "mwr_sz4_diff2048"};
    vecs[3]  = '{2'd0, 10'd5,    1'b1, 1'b1, "mwr_sz5_diff2047"};
    vecs[4]  = '{2'd0, 10'd4,    1'b0, 1'b0, "mwr_no_valid"};
    vecs[5]  = '{2'd1, 10'd0,    1'b1, 1'b1, "mrd_sz0"};
    vecs[6]  = '{2'd1, 10'd64,   1'b1, 1'b1, "mrd_sz64_exact"};
    vecs[7]  = '{2'd1, 10'd65,   1'b1, 1'b0, "mrd_sz65_short"};
    vecs[8]  = '{2'd1, 10'd68,   1'b1, 1'b0, "mrd_sz68_short"};
    vecs[9]  = '{2'd2, 10'd1023, 1'b1, 1'b1, "cpl_inf_sz1023"};
    vecs[10] = '{2'd3, 10'd0,    1'b1, 1'b0, "bad_type"};
    vecs[11] = '{2'd0, 10'd1023, 1'b1, 1'b1, "mwr_sz1023"};

    // Reset state
    #1;
    chk("rst_fc_ready", fc_ready_o, 1'b0);
    chk("rst_req_ready", req_ready_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_type_i = 2'd1;

    // Init with ignored events interleaved: early InitFC2, repeat InitFC1, unknown type
    dllp(K_INIT1, 2'd0, 8'd4, 12'd2049);
    dllp(K_INIT2, 2'd1, 8'd1, 12'd1);
    dllp(K_INIT1, 2'd0, 8'd4, 12'd16);
    dllp(K_INIT1, 2'd1, 8'd4, 12'd16);
    dllp(K_INIT1, 2'd3, 8'd9, 12'd9);
    #1 chk("init1_not_ready", fc_ready_o, 1'b0);
    dllp(K_INIT1, 2'd2, 8'd0, 12'd0);
    #1 chk("init2_not_ready", fc_ready_o, 1'b0);
    chk("pre_ready_req", req_ready_o, 1'b0);
    req_valid_i = 1'b0;
    @(negedge clk);
    #1 chk("init2_idle_not_ready", fc_ready_o, 1'b0);
    // UpdateFC finishes init; its MRd fields (1/1) must be discarded
    @(negedge clk);
    dllp_valid_i = 1'b1; dllp_kind_i = K_UPD; dllp_type_i = 2'd1;
    dllp_hdr_fc_i = 8'd1; dllp_data_fc_i = 12'd1;
    #1 chk("ready_not_same_cycle", fc_ready_o, 1'b0);
    @(negedge clk);
    dllp_valid_i = 1'b0; dllp_kind_i = 2'b00;
    #1 chk("ready_after_init2", fc_ready_o, 1'b1);
    // UpdateFC to infinite Cpl fields must be held
    dllp(K_UPD, 2'd2, 8'd1, 12'd1);

    foreach (vecs[i]) begin
      @(negedge clk);
      req_valid_i = vecs[i].vld;
      req_type_i  = vecs[i].typ;
      req_size_i  = vecs[i].size;
      #1 chk(vecs[i].name, req_ready_o, vecs[i].exp_rdy);
      req_valid_i = 1'b0;
    end

    // MWr 16DW x4 then stall; UpdateFC releases the 5th a cycle later
    reinit();
    do_init(8'd4, 12'd16, 8'd4, 12'd16, 8'd4, 12'd16);
    @(negedge clk);
    req_valid_i = 1'b1; req_type_i = 2'd0; req_size_i = 10'd16;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("mwr_grant%0d", i), req_ready_o, (i < 4) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    dllp_valid_i = 1'b1; dllp_kind_i = K_UPD; dllp_type_i = 2'd0;
    dllp_hdr_fc_i = 8'd5; dllp_data_fc_i = 12'd20;
    #1 chk("upd_same_cycle_stall", req_ready_o, 1'b0);
    @(negedge clk);
    dllp_valid_i = 1'b0; dllp_kind_i = 2'b00;
    #1 chk("upd_next_cycle_grant", req_ready_o, 1'b1);
    @(negedge clk);
    #1 chk("after_5th_stall", req_ready_o, 1'b0);
    req_valid_i = 1'b0;

    // Infinite Cpl: 1000 back-to-back grants
    reinit();
    do_init(8'd4, 12'd16, 8'd4, 12'd16, 8'd0, 12'd0);
    hold_req(2'd2, 10'd64, 1000, g);
    chk("cpl_inf_grants", g, 1000);

    // MRd header counter wrap: drive CC_hdr to 0xFF, then CL_hdr=0x02 allows 3 more
    dllp(K_UPD, 2'd1, 8'h80, 12'd16);
    hold_req(2'd1, 10'd0, 130, g);
    chk("mrd_grants_to_80", g, 128);
    dllp(K_UPD, 2'd1, 8'hFF, 12'd16);
    hold_req(2'd1, 10'd0, 130, g);
    chk("mrd_grants_to_ff", g, 127);
    dllp(K_UPD, 2'd1, 8'h02, 12'd16);
    @(negedge clk);
    req_valid_i = 1'b1; req_type_i = 2'd1; req_size_i = 10'd0;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("mrd_wrap%0d", i), req_ready_o, (i < 3) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    req_valid_i = 1'b0;

    // Reinit mid-traffic: two MWr consumed, then reinit must clear CC
    reinit();
    do_init(8'd4, 12'd16, 8'd4, 12'd16, 8'd0, 12'd0);
    hold_req(2'd0, 10'd16, 2, g);
    chk("mwr_pre_reinit", g, 2);
    @(negedge clk);
    req_valid_i = 1'b1; req_type_i = 2'd2; req_size_i = 10'd8;
    #1 chk("cpl_pre_reinit", req_ready_o, 1'b1);
    fc_reinit_i = 1'b1;
    #1 chk("reinit_same_cycle", req_ready_o, 1'b0);
    chk("reinit_fc_ready_same", fc_ready_o, 1'b0);
    @(negedge clk);
    fc_reinit_i = 1'b0;
    #1 chk("reinit_fc_ready", fc_ready_o, 1'b0);
    chk("reinit_req_ready", req_ready_o, 1'b0);
    req_valid_i = 1'b0;
    do_init(8'd4, 12'd16, 8'd4, 12'd16, 8'd0, 12'd0);
    hold_req(2'd0, 10'd16, 6, g);
    chk("mwr_after_reinit", g, 4);

    // Asynchronous reset mid-traffic
    @(negedge clk);
    req_valid_i = 1'b1; req_type_i = 2'd2; req_size_i = 10'd64;
    #1 chk("cpl_pre_rst", req_ready_o, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_fc_ready", fc_ready_o, 1'b0);
    chk("async_rst_req_ready", req_ready_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("post_rst_fc_ready", fc_ready_o, 1'b0);
    chk("post_rst_req_ready", req_ready_o, 1'b0);
    req_valid_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
